// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with PC, IR and
// retired-instruction counter; all datapath controls are Moore outputs of state and ir.
module multicycle_ctrl #(
  parameter int unsigned          PC_W      = 32,
  parameter logic [PC_W-1:0]      RESET_PC  = PC_W'(32'h28),
  parameter int unsigned          CNT_W     = 16,
  parameter int unsigned          MAX_INSTR = 43
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ins,
  input  logic [31:0]       imm,
  input  logic [25:0]       jTarget,
  input  logic              zero,
  input  logic              mem_ready,
  output logic [PC_W-1:0]   pc,
  output logic [31:0]       ir,
  output logic              RegWrite,
  output logic              ALUSrc,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Mem2Reg,
  output logic [2:0]        op,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  instr_count,
  output logic              halted
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LW  = 7'h03;
  localparam logic [6:0] OP_SW  = 7'h23;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;

  logic [2:0]       state_reg, state_next;
  logic [PC_W-1:0]  pc_reg, pc_next;
  logic [31:0]      ir_reg;
  logic [CNT_W-1:0] count_reg;
  logic             retire;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [PC_W-1:0]  br_off, jal_off;
  logic             at_limit;
  logic             unused_bits;

  assign opcode      = ir_reg[6:0];
  assign funct3      = ir_reg[14:12];
  assign br_off      = PC_W'($signed({imm[30:0], 1'b0}));
  assign jal_off     = PC_W'({jTarget, 2'b00});
  assign at_limit    = (MAX_INSTR != 0) && (count_reg == CNT_W'(MAX_INSTR));
  assign unused_bits = imm[31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      FETCH:  state_next = at_limit ? HALT : DECODE;
      DECODE: begin
        case (opcode)
          OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL: state_next = EXEC;
          default: begin state_next = FETCH; retire = 1'b1; end
        endcase
      end
      EXEC: begin
        case (opcode)
          OP_R, OP_I:   state_next = WB;
          OP_LW, OP_SW: state_next = MEM;
          default: begin state_next = FETCH; retire = 1'b1; end
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          if (opcode == OP_LW) state_next = WB;
          else begin state_next = FETCH; retire = 1'b1; end
        end
      end
      WB:      begin state_next = FETCH; retire = 1'b1; end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // The branch condition only matters when a branch retires out of EXEC.
  always_comb begin
    if (state_reg == EXEC && opcode == OP_BR && funct3 == 3'b000 && zero)
      pc_next = pc_reg + br_off;
    else if (opcode == OP_JAL)
      pc_next = pc_reg + jal_off;
    else
      pc_next = pc_reg + PC_W'(4);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
      count_reg <= '0;
    end else begin
      if (state_reg == FETCH) ir_reg <= ins;
      if (retire) begin
        pc_reg    <= pc_next;
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Mem2Reg  = 1'b0;
    op       = 3'b010;
    if (state_reg == EXEC || state_reg == MEM || state_reg == WB) begin
      ALUSrc = !(opcode == OP_R || opcode == OP_BR);
      if (opcode == OP_R && funct3 == 3'b110)      op = 3'b001;
      else if (opcode == OP_R && funct3 == 3'b111) op = 3'b000;
      else if (opcode == OP_BR)                    op = 3'b110;
    end
    if (state_reg == MEM) begin
      MemRead  = (opcode == OP_LW);
      MemWrite = (opcode == OP_SW);
    end
    if (state_reg == WB) begin
      RegWrite = 1'b1;
      Mem2Reg  = (opcode == OP_LW);
    end
  end

  assign pc          = pc_reg;
  assign ir          = ir_reg;
  assign state       = state_reg;
  assign instr_count = count_reg;
  assign halted      = (state_reg == HALT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one default instance for instruction flows,
// a second with MAX_INSTR=2 for the halt path.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [31:0] ins, ins2, imm;
  logic [25:0] jTarget;
  logic        zero, mem_ready;

  logic [31:0] pc, ir, pc2, ir2;
  logic        RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg;
  logic        RegWrite2, ALUSrc2, MemRead2, MemWrite2, Mem2Reg2;
  logic [2:0]  op, state, op2, state2;
  logic [15:0] instr_count, instr_count2;
  logic        halted, halted2;

  int tests = 0;
  int failed = 0;

  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] ORR  = 32'h0020E1B3;
  localparam logic [31:0] ANDR = 32'h0020F1B3;
  localparam logic [31:0] ADDI = 32'h00108093;
  localparam logic [31:0] LW   = 32'h0000A283;
  localparam logic [31:0] SW   = 32'h0020A023;
  localparam logic [31:0] BEQ  = 32'h00000063;
  localparam logic [31:0] BNE  = 32'h00001063;
  localparam logic [31:0] JAL  = 32'h0000006F;
  localparam logic [31:0] UNK  = 32'h0000007F;

  multicycle_ctrl dut (
    .clk(clk), .reset(rst), .ins(ins), .imm(imm), .jTarget(jTarget), .zero(zero),
    .mem_ready(mem_ready), .pc(pc), .ir(ir), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .Mem2Reg(Mem2Reg), .op(op), .state(state),
    .instr_count(instr_count), .halted(halted)
  );

  multicycle_ctrl #(.MAX_INSTR(2)) dut2 (
    .clk(clk), .reset(rst2), .ins(ins2), .imm(imm), .jTarget(jTarget), .zero(zero),
    .mem_ready(mem_ready), .pc(pc2), .ir(ir2), .RegWrite(RegWrite2), .ALUSrc(ALUSrc2),
    .MemRead(MemRead2), .MemWrite(MemWrite2), .Mem2Reg(Mem2Reg2), .op(op2), .state(state2),
    .instr_count(instr_count2), .halted(halted2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; ins = '0; ins2 = '0; imm = '0;
    jTarget = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", pc, 32'h28);
    check("rst_ir", ir, 32'h0);
    check("rst_cnt", 32'(instr_count), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_memwrite", 32'(MemWrite), 32'd0);
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_op", 32'(op), 32'b010);
    check("rst_alusrc", 32'(ALUSrc), 32'd0);

    // add: 0,1,2,4,0
    rst = 1'b0; ins = ADD;
    check("add_fetch", 32'(state), 32'd0);
    step(); check("add_decode", 32'(state), 32'd1); check("add_ir", ir, ADD);
    step(); check("add_exec", 32'(state), 32'd2); check("add_exec_rw", 32'(RegWrite), 32'd0);
    check("add_exec_alusrc", 32'(ALUSrc), 32'd0);
    step(); check("add_wb", 32'(state), 32'd4); check("add_wb_rw", 32'(RegWrite), 32'd1);
    step(); check("add_done", 32'(state), 32'd0); check("add_pc", pc, 32'h2C);
    check("add_cnt", 32'(instr_count), 32'd1); check("add_rw_off", 32'(RegWrite), 32'd0);

    // lw with three wait cycles
    ins = LW; mem_ready = 1'b0;
    step(); step(); check("lw_exec_mr", 32'(MemRead), 32'd0); check("lw_exec_alusrc", 32'(ALUSrc), 32'd1);
    step(); check("lw_mem1", 32'(MemRead), 32'd1);
    step(); check("lw_mem2", 32'(MemRead), 32'd1);
    step(); check("lw_mem3", 32'(MemRead), 32'd1);
    step(); check("lw_mem4", 32'(MemRead), 32'd1); check("lw_mem4_state", 32'(state), 32'd3);
    mem_ready = 1'b1;
    step(); check("lw_wb_state", 32'(state), 32'd4); check("lw_wb_m2r", 32'(Mem2Reg), 32'd1);
    check("lw_wb_rw", 32'(RegWrite), 32'd1); check("lw_wb_mr", 32'(MemRead), 32'd0);
    step(); check("lw_pc", pc, 32'h30); check("lw_cnt", 32'(instr_count), 32'd2);
    mem_ready = 1'b0;

    // beq taken at 0x30
    ins = BEQ; imm = 32'd4; zero = 1'b1;
    step(); step(); check("beq_op", 32'(op), 32'b110); check("beq_alusrc", 32'(ALUSrc), 32'd0);
    step(); check("beq_state", 32'(state), 32'd0); check("beq_pc", pc, 32'h38);
    // beq not taken at 0x38
    zero = 1'b0;
    step(); step(); step(); check("beq_nt_pc", pc, 32'h3C);
    // bne-encoded branch with zero=1 falls through
    ins = BNE; zero = 1'b1;
    step(); step(); step(); check("bne_pc", pc, 32'h40);
    zero = 1'b0;

    // jal at 0x40
    ins = JAL; jTarget = 26'd3;
    step(); step(); check("jal_exec_rw", 32'(RegWrite), 32'd0);
    step(); check("jal_pc", pc, 32'h4C); check("jal_cnt", 32'(instr_count), 32'd6);
    jTarget = '0;

    // unknown opcode: 2 cycles, pc+4
    ins = UNK;
    step(); check("unk_decode", 32'(state), 32'd1);
    step(); check("unk_state", 32'(state), 32'd0); check("unk_pc", pc, 32'h50);

    // or / and op codes
    ins = ORR;
    step(); step(); check("or_op", 32'(op), 32'b001);
    step(); step(); ins = ANDR;
    step(); step(); check("and_op", 32'(op), 32'b000);
    step(); check("and_wb_op", 32'(op), 32'b000);
    step(); check("and_pc", pc, 32'h58);

    // addi
    ins = ADDI;
    step(); step(); check("addi_alusrc", 32'(ALUSrc), 32'd1); check("addi_op", 32'(op), 32'b010);
    step(); step(); check("addi_cnt", 32'(instr_count), 32'd10);

    // sw with reset during wait
    ins = SW; mem_ready = 1'b0;
    step(); step(); step(); check("sw_mem_mw", 32'(MemWrite), 32'd1); check("sw_mem_mr", 32'(MemRead), 32'd0);
    step(); check("sw_wait_mw", 32'(MemWrite), 32'd1); check("sw_wait_state", 32'(state), 32'd3);
    #3 rst = 1'b1;
    #1 check("sw_rst_mw", 32'(MemWrite), 32'd0); check("sw_rst_state", 32'(state), 32'd0);
    check("sw_rst_pc", pc, 32'h28); check("sw_rst_cnt", 32'(instr_count), 32'd0);
    step(); rst = 1'b0;

    // halt after two addi on the MAX_INSTR=2 instance
    rst2 = 1'b0; ins2 = ADDI;
    repeat (8) step();
    check("h_pc", pc2, 32'h30); check("h_cnt", 32'(instr_count2), 32'd2); check("h_fetch", 32'(state2), 32'd0);
    step(); check("h_state", 32'(state2), 32'd5); check("h_halted", 32'(halted2), 32'd1);
    repeat (2) step();
    check("h_frozen_pc", pc2, 32'h30); check("h_frozen_state", 32'(state2), 32'd5);
    check("h_frozen_cnt", 32'(instr_count2), 32'd2); check("h_rw", 32'(RegWrite2), 32'd0);
    rst2 = 1'b1;
    #1 check("h_rst_state", 32'(state2), 32'd0); check("h_rst_pc", pc2, 32'h28);
    check("h_rst_halted", 32'(halted2), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
